// File: rtl/ahb_pkg.sv
// AHB-Lite bus encodings and data-phase state codes shared by the SRAM slave.
// Pure declarations: no latency or backpressure of its own.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic [2:0] DP_IDLE = 3'd0;
  localparam logic [2:0] DP_WAIT = 3'd1;
  localparam logic [2:0] DP_LAST = 3'd2;
  localparam logic [2:0] DP_ERR1 = 3'd3;
  localparam logic [2:0] DP_ERR2 = 3'd4;

  // Control captured in the address phase and used during the data phase.
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [2:0] off;
  } dp_ctrl_t;

  // Byte-lane enables for a transfer of 2^size bytes starting at lane offset.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Byte-enabled memory: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read has zero latency; never stalls.
module ahb_sram_bytemem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      hclk,
  input  logic                      wr_vld,
  input  logic [ADDR_WIDTH-1:0]     wr_idx,
  input  logic [DATA_WIDTH/8-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0]     wr_dat,
  input  logic [ADDR_WIDTH-1:0]     rd_idx,
  output logic [DATA_WIDTH-1:0]     rd_dat
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge hclk) begin
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wr_vld && wr_be[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave; data phase takes WAIT_STATES+1 cycles (errors take two).
// Backpressure: hreadyout low in wait states and the first error cycle.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0] WS_LAST = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [2:0]            state, state_nxt;
  logic [2:0]            wait_cnt, wait_cnt_nxt;
  dp_ctrl_t              cap;
  logic [AW-1:0]         cap_idx;
  logic                  accept;
  logic                  req_err;
  logic [7:0]            align_mask;
  logic                  rd_load;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] mem_rd_dat;
  logic [DATA_WIDTH-1:0] rd_merged;
  logic                  wr_vld;
  logic [NB-1:0]         wr_be;
  logic                  unused_ctrl;

  assign unused_ctrl = ^{hburst, hprot, hmastlock};

  // Only states that present hreadyout=1 may take a new address phase.
  assign accept = hsel && hready && hreadyout &&
                  (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  assign align_mask = (8'd1 << hsize) - 8'd1;
  assign req_err    = (hsize > 3'(LANE_BITS)) ||
                      (|(haddr[7:0] & align_mask)) ||
                      ((haddr >> LANE_BITS) >= 32'(MEM_DEPTH));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      DP_WAIT: begin
        if (wait_cnt == WS_LAST) state_nxt = DP_LAST;
        else                     wait_cnt_nxt = wait_cnt + 3'd1;
      end
      DP_ERR1: state_nxt = DP_ERR2;
      default: begin
        state_nxt = DP_IDLE;
        if (accept) begin
          if (req_err) begin
            state_nxt = DP_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = DP_WAIT;
            wait_cnt_nxt = '0;
          end else begin
            state_nxt = DP_LAST;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      DP_WAIT: hreadyout = 1'b0;
      DP_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      DP_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  // With no wait states the read is launched straight from the bus address.
  assign rd_idx  = (state == DP_WAIT) ? cap_idx : haddr[LANE_BITS +: AW];
  assign rd_load = (accept && !req_err && (WAIT_STATES == 0) && !hwrite) ||
                   ((state == DP_WAIT) && (wait_cnt == WS_LAST) && !cap.write);

  assign wr_vld = (state == DP_LAST) && cap.write;
  assign wr_be  = NB'(lane_mask(cap.size, cap.off));

  always_comb begin
    rd_merged = mem_rd_dat;
    for (int b = 0; b < NB; b++) begin
      if (wr_vld && wr_be[b] && (cap_idx == rd_idx)) begin
        rd_merged[8*b +: 8] = hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= DP_IDLE;
      wait_cnt <= '0;
      cap      <= '0;
      cap_idx  <= '0;
      hrdata   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        cap.write <= hwrite;
        cap.size  <= hsize;
        cap.off   <= 3'(haddr[LANE_BITS-1:0]);
        cap_idx   <= haddr[LANE_BITS +: AW];
      end
      if (rd_load) hrdata <= rd_merged;
    end
  end

  ahb_sram_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .hclk   (hclk),
    .wr_vld (wr_vld),
    .wr_idx (cap_idx),
    .wr_be  (wr_be),
    .wr_dat (hwdata),
    .rd_idx (rd_idx),
    .rd_dat (mem_rd_dat)
  );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance driven by a pipelined master,
// checked against a byte-array memory model.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel_a      [2];
  logic [31:0] haddr_a     [2];
  logic        hwrite_a    [2];
  logic [2:0]  hsize_a     [2];
  logic [2:0]  hburst_a    [2];
  logic [1:0]  htrans_a    [2];
  logic [3:0]  hprot_a     [2];
  logic        hmastlock_a [2];
  logic [31:0] hwdata_a    [2];
  logic        hreadyout_a [2];
  logic        hresp_a     [2];
  logic [31:0] hrdata_a    [2];

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_a[0]), .haddr(haddr_a[0]),
    .hwrite(hwrite_a[0]), .hsize(hsize_a[0]), .hburst(hburst_a[0]), .htrans(htrans_a[0]),
    .hprot(hprot_a[0]), .hmastlock(hmastlock_a[0]), .hready(hreadyout_a[0]),
    .hwdata(hwdata_a[0]), .hreadyout(hreadyout_a[0]), .hresp(hresp_a[0]), .hrdata(hrdata_a[0])
  );

  ahb_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel_a[1]), .haddr(haddr_a[1]),
    .hwrite(hwrite_a[1]), .hsize(hsize_a[1]), .hburst(hburst_a[1]), .htrans(htrans_a[1]),
    .hprot(hprot_a[1]), .hmastlock(hmastlock_a[1]), .hready(hreadyout_a[1]),
    .hwdata(hwdata_a[1]), .hreadyout(hreadyout_a[1]), .hresp(hresp_a[1]), .hrdata(hrdata_a[1])
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } tx_t;

  tx_t         txq [$];
  logic [7:0]  mem_m [2][1024];
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;
  int          low_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    return (s > 3'd2) || ((a & ((32'd1 << s) - 32'd1)) != 32'd0) || ((a >> 2) >= 32'd256);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int base;
    base = int'({a[9:2], 2'b00});
    return {mem_m[d][base+3], mem_m[d][base+2], mem_m[d][base+1], mem_m[d][base]};
  endfunction

  task automatic model_write(input int d, input tx_t t);
    for (int k = 0; k < (1 << t.size); k++) begin
      int a;
      int lane;
      a    = int'(t.addr) + k;
      lane = int'(t.addr[1:0]) + k;
      mem_m[d][a] = t.wdata[8*lane +: 8];
    end
  endtask

  function automatic void push(input logic [31:0] a, input logic w, input logic [2:0] s,
                               input logic [1:0] tr, input logic [31:0] wd);
    tx_t t;
    t.addr = a; t.wr = w; t.size = s; t.trans = tr; t.wdata = wd;
    txq.push_back(t);
  endfunction

  // Pipelined master: the head of txq is in its address phase while dp is in its data phase.
  task automatic run(input int d);
    tx_t         dp;
    bit          dp_vld;
    int          waits;
    int          cyc;
    int          ws;
    logic        rdy;
    logic [31:0] exp_rd;
    ws = (d == 0) ? 0 : 3;
    dp_vld = 0; waits = 0; cyc = 0; low_cnt = 0;
    while ((txq.size() != 0 || dp_vld) && cyc < 4000) begin
      if (txq.size() != 0) begin
        hsel_a[d]   = 1'b1;
        haddr_a[d]  = txq[0].addr;
        hwrite_a[d] = txq[0].wr;
        hsize_a[d]  = txq[0].size;
        htrans_a[d] = txq[0].trans;
      end else begin
        hsel_a[d]   = 1'b0;
        htrans_a[d] = 2'b00;
        haddr_a[d]  = $urandom;
      end
      hburst_a[d]    = 3'($urandom);
      hprot_a[d]     = 4'($urandom);
      hmastlock_a[d] = 1'($urandom);
      hwdata_a[d]    = (dp_vld && dp.wr) ? dp.wdata : $urandom;
      @(negedge hclk);
      rdy = hreadyout_a[d];
      if (!rdy) low_cnt++;
      exp_rd = last_rd[d];
      if (!dp_vld) begin
        chk("idle_ready", 32'(rdy), 32'd1);
        chk("idle_resp", 32'(hresp_a[d]), 32'd0);
      end else if (is_err(dp.addr, dp.size)) begin
        chk("err_ready", 32'(rdy), 32'(waits != 0));
        chk("err_resp", 32'(hresp_a[d]), 32'd1);
      end else begin
        chk("ok_ready", 32'(rdy), 32'(waits == ws));
        chk("ok_resp", 32'(hresp_a[d]), 32'd0);
        if (rdy && !dp.wr) exp_rd = model_word(d, dp.addr);
      end
      chk("hrdata", hrdata_a[d], exp_rd);
      @(posedge hclk);
      #1;
      cyc++;
      if (rdy) begin
        if (dp_vld && !is_err(dp.addr, dp.size)) begin
          if (dp.wr) model_write(d, dp);
          else       last_rd[d] = exp_rd;
        end
        dp_vld = 0;
        waits  = 0;
        if (txq.size() != 0) begin
          dp     = txq.pop_front();
          dp_vld = dp.trans[1];
        end
      end else begin
        waits++;
      end
    end
    hsel_a[d]   = 1'b0;
    htrans_a[d] = 2'b00;
    checks++;
    assert (txq.size() == 0 && !dp_vld)
    else begin
      errors++;
      $error("FAIL run_timeout observed=%0d pending, required 0", txq.size() + int'(dp_vld));
      txq.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [4];
    logic [31:0] old8;
    for (int d = 0; d < 2; d++) begin
      hsel_a[d] = 1'b0; haddr_a[d] = '0; hwrite_a[d] = 1'b0; hsize_a[d] = 3'd2;
      hburst_a[d] = '0; htrans_a[d] = 2'b00; hprot_a[d] = '0; hmastlock_a[d] = 1'b0;
      hwdata_a[d] = '0; last_rd[d] = '0;
    end
    hreset = 1'b0;
    #1 hreset = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(hreadyout_a[d]), 32'd1);
      chk("reset_resp", 32'(hresp_a[d]), 32'd0);
      chk("reset_rdata", hrdata_a[d], 32'd0);
    end
    @(posedge hclk);
    @(posedge hclk);
    #1 hreset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) push(32'(i * 4), 1'b1, 3'd2, 2'b10, $urandom);
      run(d);
    end

    push(32'h10, 1'b1, 3'd2, 2'b10, 32'hDEADBEEF);
    push(32'h10, 1'b0, 3'd2, 2'b10, 32'h0);
    run(0);
    chk("word_rw_rdata", hrdata_a[0], 32'hDEADBEEF);
    chk("word_rw_stall", 32'(low_cnt), 32'd0);

    push(32'h10, 1'b1, 3'd2, 2'b10, 32'h11223344);
    push(32'h13, 1'b1, 3'd0, 2'b10, {8'hAA, 24'($urandom)});
    push(32'h10, 1'b0, 3'd2, 2'b10, 32'h0);
    run(0);
    chk("byte_write_merge", hrdata_a[0], 32'hAA223344);

    push(32'h20, 1'b1, 3'd2, 2'b10, 32'h5);
    push(32'h20, 1'b0, 3'd2, 2'b10, 32'h0);
    run(0);
    chk("raw_forward", hrdata_a[0], 32'h00000005);

    push(32'h400, 1'b0, 3'd2, 2'b10, 32'h0);
    run(0);
    chk("range_err_stall", 32'(low_cnt), 32'd1);
    push(32'h400, 1'b1, 3'd2, 2'b10, 32'h12345678);
    push(32'h22, 1'b1, 3'd2, 2'b10, 32'hCAFEF00D);
    push(32'h20, 1'b1, 3'd3, 2'b10, 32'h0BADBEEF);
    push(32'h0, 1'b0, 3'd2, 2'b10, 32'h0);
    push(32'h20, 1'b0, 3'd2, 2'b10, 32'h0);
    run(0);
    chk("err_no_write", hrdata_a[0], 32'h00000005);

    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      push(32'(i * 4), 1'b1, 3'd2, (i == 0) ? 2'b10 : 2'b11, w[i]);
    end
    run(1);
    chk("incr4_stall", 32'(low_cnt), 32'd12);
    for (int i = 0; i < 4; i++) push(32'(i * 4), 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'h0);
    run(1);
    chk("incr4_readback", hrdata_a[1], w[3]);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        logic [31:0] a;
        logic [2:0]  s;
        logic [1:0]  tr;
        if ($urandom_range(0, 9) == 0)      a = 32'($urandom_range(1024, 4095));
        else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
        else                                a = 32'($urandom_range(0, 1023));
        s  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << s) - 32'd1);
        tr = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        push(a, 1'($urandom), s, tr, $urandom);
      end
      run(d);
    end

    old8 = model_word(1, 32'h8);
    hsel_a[1] = 1'b1; haddr_a[1] = 32'h8; hwrite_a[1] = 1'b1;
    hsize_a[1] = 3'd2; htrans_a[1] = 2'b10;
    @(posedge hclk);
    #1;
    hsel_a[1] = 1'b0; htrans_a[1] = 2'b00; hwdata_a[1] = ~old8;
    @(negedge hclk);
    chk("abort_in_wait", 32'(hreadyout_a[1]), 32'd0);
    #2 hreset = 1'b1;
    #1;
    chk("abort_ready", 32'(hreadyout_a[1]), 32'd1);
    chk("abort_resp", 32'(hresp_a[1]), 32'd0);
    chk("abort_rdata", hrdata_a[1], 32'd0);
    @(posedge hclk);
    #1 hreset = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    push(32'h8, 1'b0, 3'd2, 2'b10, 32'h0);
    run(1);
    chk("abort_mem_kept", hrdata_a[1], old8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width; legal values 32 or 64.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of DATA_WIDTH-bit words in the memory.
REQ-003 SHALL have parameter WAIT_STATES, default 0, wait cycles inserted per OKAY transfer; legal range 0..7.
REQ-004 SHALL have port hclk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port hreset  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port hsel  input  1  slave select.
REQ-007 SHALL have port haddr  input  32  byte address.
REQ-008 SHALL have ports hwrite  input  1; hsize  input  3; hburst  input  3; htrans  input  2; hprot  input  4; hmastlock  input  1 (standard AHB-Lite meaning).
REQ-009 SHALL have port hready  input  1  bus ready (address phase accepted when high).
REQ-010 SHALL have port hwdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports hreadyout  output  1; hresp  output  1; hrdata  output  DATA_WIDTH.

Function
REQ-012 SHALL accept an address phase when hsel=1, hready=1 and htrans is NONSEQ(10) or SEQ(11); IDLE(00) and BUSY(01) SHALL get a zero-wait OKAY data phase with no memory access.
REQ-013 SHALL capture haddr, hwrite and hsize at the accepting edge; data phase begins the next cycle.
REQ-014 SHALL follow the haddr presented on every beat; hburst SHALL NOT drive address generation (INCR and WRAP sequences are the master's responsibility).
REQ-015 SHALL flag an error when any of these holds: hsize > log2(DATA_WIDTH/8); haddr not aligned to 2^hsize; word index haddr[31:log2(DATA_WIDTH/8)] >= MEM_DEPTH.
REQ-016 Data-phase FSM SHALL have states DP_IDLE, DP_WAIT, DP_LAST, DP_ERR1, DP_ERR2.
REQ-017 DP_IDLE: hreadyout=1, hresp=0; on valid accept go to DP_WAIT if WAIT_STATES>0 else DP_LAST; on errored accept go to DP_ERR1.
REQ-018 DP_WAIT: hreadyout=0, hresp=0; an internal counter SHALL count WAIT_STATES cycles, then the FSM SHALL go to DP_LAST.
REQ-019 DP_LAST: hreadyout=1, hresp=0; the FSM SHALL then follow the REQ-017 rules for any new accept, otherwise go to DP_IDLE.
REQ-020 DP_ERR1: hreadyout=0, hresp=1, then DP_ERR2. DP_ERR2: hreadyout=1, hresp=1, then the REQ-017 rules apply.
REQ-021 An errored transfer SHALL NOT modify memory; hrdata SHALL hold its last value during DP_ERR1 and DP_ERR2.
REQ-022 Writes SHALL sample hwdata at the edge ending DP_LAST.
REQ-023 Writes SHALL update only the 2^hsize little-endian byte lanes starting at haddr[log2(DATA_WIDTH/8)-1:0].
REQ-024 Read data SHALL be registered into hrdata at the edge entering DP_LAST; all lanes are driven from the addressed word.
REQ-025 Read-after-write: if a write completes on the same edge that loads hrdata for the same word, the written bytes SHALL be forwarded into hrdata (byte-wise merge).
REQ-026 A new address phase SHALL be accepted during DP_LAST or DP_ERR2 (pipelined back-to-back transfers), with no idle cycle.
REQ-027 hprot and hmastlock SHALL be ignored.

Reset
REQ-028 On hreset=1, asynchronously: FSM=DP_IDLE, wait counter=0, hreadyout=1, hresp=0, hrdata=0, captured address/control cleared.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset mid-data-phase SHALL abort the transfer; an aborted write SHALL NOT modify memory.

Structure
REQ-031 Package ahb_pkg SHALL hold the HTRANS, HSIZE and HBURST encodings and the data-phase state encoding.
REQ-032 The byte-enabled memory array SHALL be the sub-module ahb_sram_bytemem (one write port with byte enables, one read port).
REQ-033 All widths SHALL derive from DATA_WIDTH and MEM_DEPTH; there SHALL be no hard-coded lane counts.

Verification
REQ-034 DW=32, WS=0: NONSEQ write word 0x10 = 0xDEADBEEF, then read 0x10 -> hrdata=0xDEADBEEF, OKAY, no hreadyout low.
REQ-035 Byte write 0xAA at 0x13 over 0x11223344 at word 0x10, read back -> 0xAA223344.
REQ-036 Write 0x5 to 0x20 immediately followed by pipelined read of 0x20 -> hrdata=0x00000005 (forwarding).
REQ-037 Read 0x400 (MEM_DEPTH=256) -> one cycle hreadyout=0/hresp=1, then hreadyout=1/hresp=1; memory unchanged.
REQ-038 WS=3, INCR4 write 0x0..0xC -> each beat has 3 cycles of hreadyout=0 then 1; readback correct.
REQ-039 Assert hreset in DP_WAIT of a write to 0x8 -> hreadyout=1, hresp=0, hrdata=0 immediately; word 0x8 retains its old value.
